poly_mix_pwm: RTL and testbench

POLY_MIX_PWM -- requirements
Module: poly_mix_pwm

---
 rtl/poly_mix_pwm.sv | 197 +++++++++++++++++++
 tb/tb_poly_mix_pwm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/poly_mix_pwm.sv
// poly_mix_pwm: averages up to NUM_VOICES gated voice samples with a
// fixed-latency serial mixer (accumulate, restoring divide, load) and drives
// the result out as a SAMPLE_W-bit PWM whose duty only changes on wrap.
// Optional feature macro: POLY_MIX_MIDSCALE_IDLE_EN -- when defined, a mix
// with no active voices and the reset value of mix_out/duty are midscale
// (2^(SAMPLE_W-1)) instead of 0.
module poly_mix_pwm #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SAMPLE_W   = 9
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           cs,
    input  logic                           sample_now,
    input  logic [NUM_VOICES-1:0]          voice_active,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] samples,
    output logic [SAMPLE_W-1:0]            mix_out,
    output logic                           mix_ready,
    output logic                           busy,
    output logic                           overrun,
    output logic                           pwm_o
);

    localparam int unsigned ACC_W    = SAMPLE_W + $clog2(NUM_VOICES);
    localparam int unsigned CNT_W    = $clog2(NUM_VOICES + 1);
    localparam int unsigned REM_W    = CNT_W + 1;
    localparam int unsigned STEP_MAX = (NUM_VOICES > ACC_W) ? NUM_VOICES : ACC_W;
    localparam int unsigned STEP_W   = $clog2(STEP_MAX + 1);

`ifdef POLY_MIX_MIDSCALE_IDLE_EN
    localparam logic [SAMPLE_W-1:0] SILENT = {1'b1, {(SAMPLE_W-1){1'b0}}};
`else
    localparam logic [SAMPLE_W-1:0] SILENT = '0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        LOAD   = 2'd3
    } state_t;

    state_t                         state;
    state_t                         state_next;
    logic [STEP_W-1:0]              step;
    logic [NUM_VOICES*SAMPLE_W-1:0] smp_q;
    logic [NUM_VOICES-1:0]          mask_q;
    logic [ACC_W-1:0]               acc;
    logic [CNT_W-1:0]               act_cnt;
    logic [CNT_W-1:0]               rem;
    logic [SAMPLE_W-1:0]            duty;
    logic [SAMPLE_W-1:0]            pwm_cnt;

    logic                           start_c;
    logic                           accum_last_c;
    logic                           div_last_c;
    logic [REM_W-1:0]               rem_shift_c;
    logic [REM_W-1:0]               rem_sub_c;
    logic                           div_ge_c;
    logic [CNT_W-1:0]               rem_new_c;
    logic [SAMPLE_W-1:0]            pwm_cnt_next_c;
    logic [SAMPLE_W-1:0]            duty_next_c;

    // Mixer state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; cs high forces the mixer back to IDLE.
    always_comb begin
        state_next   = state;
        start_c      = 1'b0;
        accum_last_c = (step == STEP_W'(NUM_VOICES - 1));
        div_last_c   = (step == STEP_W'(ACC_W - 1));
        unique case (state)
            IDLE: begin
                start_c = sample_now && !cs;
                if (start_c) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (accum_last_c) begin
                    state_next = DIVIDE;
                end
            end
            DIVIDE: begin
                if (div_last_c) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (cs) begin
            state_next = IDLE;
        end
    end

    // One restoring-divide step: quotient bits shift into acc as the dividend shifts out.
    always_comb begin
        rem_shift_c = {rem, acc[ACC_W-1]};
        rem_sub_c   = rem_shift_c - {1'b0, act_cnt};
        div_ge_c    = (rem_shift_c >= {1'b0, act_cnt});
        rem_new_c   = div_ge_c ? CNT_W'(rem_sub_c) : CNT_W'(rem_shift_c);
    end

    // Mixer datapath: capture, serial accumulate, serial divide.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            step    <= '0;
            smp_q   <= '0;
            mask_q  <= '0;
            acc     <= '0;
            act_cnt <= '0;
            rem     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_c) begin
                        step    <= '0;
                        smp_q   <= samples;
                        mask_q  <= voice_active;
                        acc     <= '0;
                        act_cnt <= '0;
                        rem     <= '0;
                    end
                end
                ACCUM: begin
                    if (mask_q[0]) begin
                        acc     <= acc + ACC_W'(smp_q[SAMPLE_W-1:0]);
                        act_cnt <= act_cnt + CNT_W'(1);
                    end
                    smp_q  <= smp_q >> SAMPLE_W;
                    mask_q <= mask_q >> 1;
                    step   <= accum_last_c ? '0 : step + STEP_W'(1);
                end
                DIVIDE: begin
                    rem  <= rem_new_c;
                    acc  <= {acc[ACC_W-2:0], div_ge_c};
                    step <= step + STEP_W'(1);
                end
                LOAD: begin
                    step <= '0;
                end
                default: begin
                    step <= '0;
                end
            endcase
        end
    end

    // Mixer outputs: result load, ready/overrun pulses and busy flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mix_out   <= SILENT;
            mix_ready <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mix_ready <= (state == LOAD) && !cs;
            busy      <= (state_next != IDLE);
            overrun   <= sample_now && !cs && (state != IDLE);
            if ((state == LOAD) && !cs) begin
                mix_out <= (act_cnt == '0) ? SILENT : acc[SAMPLE_W-1:0];
            end
        end
    end

    // PWM next values: duty only reloads as the counter wraps to zero.
    always_comb begin
        pwm_cnt_next_c = pwm_cnt + SAMPLE_W'(1);
        duty_next_c    = (pwm_cnt_next_c == '0) ? mix_out : duty;
    end

    // Free-running PWM counter, duty register and registered compare output.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pwm_cnt <= '0;
            duty    <= SILENT;
            pwm_o   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt_next_c;
            duty    <= duty_next_c;
            pwm_o   <= !cs && (pwm_cnt_next_c < duty_next_c);
        end
    end

endmodule

// File: tb/tb_poly_mix_pwm.sv
// Self-checking bench for poly_mix_pwm: directed mixes feed an expected-result
// scoreboard that a negedge monitor drains on every mix_ready pulse.
module tb_poly_mix_pwm;

    localparam int unsigned NV  = 4;
    localparam int unsigned SW  = 9;
    localparam int unsigned LAT = 17;
    localparam int unsigned PER = 512;

`ifdef POLY_MIX_MIDSCALE_IDLE_EN
    localparam logic [SW-1:0] SILENT = 9'd256;
`else
    localparam logic [SW-1:0] SILENT = 9'd0;
`endif

    logic             clk = 1'b0;
    logic             n_rst;
    logic             cs;
    logic             sample_now;
    logic [NV-1:0]    voice_active;
    logic [NV*SW-1:0] samples;
    logic [SW-1:0]    mix_out;
    logic             mix_ready;
    logic             busy;
    logic             overrun;
    logic             pwm_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ovr_cnt  = 0;

    logic [SW-1:0] exp_q[$];
    int            start_q[$];
    logic [SW-1:0] mon_e;
    int            mon_s;

    poly_mix_pwm #(.NUM_VOICES(NV), .SAMPLE_W(SW)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .cs           (cs),
        .sample_now   (sample_now),
        .voice_active (voice_active),
        .samples      (samples),
        .mix_out      (mix_out),
        .mix_ready    (mix_ready),
        .busy         (busy),
        .overrun      (overrun),
        .pwm_o        (pwm_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Edge counter since reset release; modulo PER it equals the PWM counter.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) cyc = 0;
        else        cyc = cyc + 1;
    end

    // Monitor: drain the scoreboard on each mix_ready pulse.
    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (mix_ready) begin
            if (exp_q.size() == 0) begin
                check("mix_ready_unexpected", int'(mix_ready), 0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_s = start_q.pop_front();
                check("mix_out", int'(mix_out), int'(mon_e));
                check("mix_latency", cyc + 1 - mon_s, LAT);
            end
        end
    end

    task automatic strobe(input logic [NV-1:0] m, input logic [NV*SW-1:0] s,
                          input bit push, input logic [SW-1:0] e);
        @(negedge clk);
        voice_active = m;
        samples      = s;
        sample_now   = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            exp_q.push_back(e);
            start_q.push_back(cyc);
        end
        @(negedge clk);
        sample_now = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && !(exp_q.size() == 0 && !busy); i++) @(negedge clk);
        check("mix_done_in_time", exp_q.size(), 0);
    endtask

    task automatic do_mix(input logic [NV-1:0] m, input logic [NV*SW-1:0] s,
                          input logic [SW-1:0] e);
        strobe(m, s, 1'b1, e);
        wait_done();
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 1100 && (cyc % PER) != p; i++) @(negedge clk);
        check("pwm_phase_reached", cyc % PER, p);
    endtask

    task automatic count_period(output int highs);
        highs = 0;
        for (int i = 0; i < PER; i++) begin
            @(negedge clk);
            highs += int'(pwm_o);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mix_out"},   int'(mix_out),   int'(SILENT));
        check({tag, "_mix_ready"}, int'(mix_ready), 0);
        check({tag, "_busy"},      int'(busy),      0);
        check({tag, "_overrun"},   int'(overrun),   0);
        check({tag, "_pwm_o"},     int'(pwm_o),     0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    initial begin
        int highs;
        int o0;
        n_rst        = 1'b0;
        cs           = 1'b0;
        sample_now   = 1'b0;
        voice_active = '0;
        samples      = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        n_rst = 1'b1;

        // Basic averages, including empty and odd-count masks.
        do_mix(4'b1111, {9'd400, 9'd300, 9'd200, 9'd100}, 9'd250);
        do_mix(4'b0101, {9'd450, 9'd300, 9'd50,  9'd100}, 9'd200);
        do_mix(4'b0001, {9'd0,   9'd0,   9'd0,   9'd511}, 9'd511);
        do_mix(4'b0000, {9'd1,   9'd2,   9'd3,   9'd4},   SILENT);
        do_mix(4'b0111, {9'd500, 9'd31,  9'd20,  9'd10},  9'd20);

        // Strobe while busy: dropped with a single overrun pulse.
        o0 = ovr_cnt;
        strobe(4'b1111, {9'd400, 9'd300, 9'd200, 9'd100}, 1'b1, 9'd250);
        repeat (3) @(negedge clk);
        strobe(4'b0001, {9'd0, 9'd0, 9'd0, 9'd7}, 1'b0, 9'd0);
        wait_done();
        check("overrun_pulses", ovr_cnt - o0, 1);

        // PWM duty 128, then a mid-period change to 384 that waits for the wrap.
        do_mix(4'b0001, {9'd0, 9'd0, 9'd0, 9'd128}, 9'd128);
        wait_phase(PER - 1);
        count_period(highs);
        check("pwm_high_128", highs, 128);
        wait_phase(199);
        do_mix(4'b0001, {9'd0, 9'd0, 9'd0, 9'd384}, 9'd384);
        highs = 0;
        for (int i = 0; i < 600 && (cyc % PER) != PER - 1; i++) begin
            @(negedge clk);
            highs += int'(pwm_o);
        end
        check("pwm_rest_of_period_old_duty", highs, 0);
        count_period(highs);
        check("pwm_high_384", highs, 384);

        // cs abort at cycle 8 of a mix.
        o0 = ovr_cnt;
        strobe(4'b1111, {9'd400, 9'd300, 9'd200, 9'd100}, 1'b1, 9'd250);
        repeat (7) @(negedge clk);
        cs = 1'b1;
        exp_q.delete();
        start_q.delete();
        @(negedge clk);
        check("cs_pwm_o", int'(pwm_o), 0);
        check("cs_busy", int'(busy), 0);
        strobe(4'b1111, {9'd400, 9'd300, 9'd200, 9'd100}, 1'b0, 9'd0);
        check("cs_strobe_busy", int'(busy), 0);
        repeat (20) @(negedge clk);
        check("cs_mix_out_kept", int'(mix_out), 384);
        check("cs_overrun", ovr_cnt - o0, 0);
        check("cs_pwm_o_held", int'(pwm_o), 0);
        cs = 1'b0;
        do_mix(4'b0101, {9'd450, 9'd300, 9'd50, 9'd100}, 9'd200);

        // Reset in the middle of DIVIDE.
        strobe(4'b1111, {9'd400, 9'd300, 9'd200, 9'd100}, 1'b1, 9'd250);
        repeat (8) @(negedge clk);
        n_rst = 1'b0;
        #1;
        exp_q.delete();
        start_q.delete();
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        do_mix(4'b1111, {9'd400, 9'd300, 9'd200, 9'd100}, 9'd250);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
